// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter: state encoding, default tag
// nibble and the source-tag byte builder.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSendTag,
    StWaitTag,
    StSendData,
    StWaitData
  } arb_state_e;

  localparam logic [3:0] TagHiDefault = 4'hA;

  // Tag byte is {fixed upper nibble, requester index}; callers resize to DBIT.
  function automatic logic [7:0] tag_byte(input logic [3:0] hi, input logic [3:0] id);
    return {hi, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: picks the lowest requesting index at or
// after ptr, wrapping past NREQ-1 back to 0.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    any_req
);

  localparam int unsigned IW = $clog2(NREQ);

  int unsigned idx;
  logic        found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NREQ byte producers.
// Define UART_ARB_SRC_TAG_EN to precede each data byte with a source-tag frame.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DBIT = 8
`ifdef UART_ARB_SRC_TAG_EN
  ,
  parameter logic [3:0]  TAG_HI = TagHiDefault
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBIT-1:0]    req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_din,
  input  logic                    tx_done_tick,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int unsigned IW = $clog2(NREQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          tx_start_q, tx_start_d;
  logic [DBIT-1:0] tx_din_q, tx_din_d;
  logic          busy_q, busy_d;
`ifdef UART_ARB_SRC_TAG_EN
  logic [DBIT-1:0] data_q, data_d;
`endif

  logic [IW-1:0]   sel;
  logic            any_req;
  logic [DBIT-1:0] sel_data;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (ptr_q),
    .sel    (sel),
    .any_req(any_req)
  );

  assign sel_data = req_data[32'(sel)*DBIT +: DBIT];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    req_ready  = '0;
`ifdef UART_ARB_SRC_TAG_EN
    data_d     = data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          req_ready[sel] = 1'b1;
          grant_id_d     = sel;
          ptr_d          = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
          tx_start_d     = 1'b1;
`ifdef UART_ARB_SRC_TAG_EN
          data_d   = sel_data;
          tx_din_d = DBIT'(tag_byte(TAG_HI, 4'(sel)));
          state_d  = StSendTag;
`else
          tx_din_d = sel_data;
          state_d  = StSendData;
`endif
        end
      end
`ifdef UART_ARB_SRC_TAG_EN
      StSendTag: state_d = StWaitTag;
      StWaitTag: begin
        if (tx_done_tick) begin
          state_d    = StSendData;
          tx_start_d = 1'b1;
          tx_din_d   = data_q;
        end
      end
`endif
      // A done tick during the start cycle belongs to no frame of ours.
      StSendData: state_d = StWaitData;
      StWaitData: begin
        if (tx_done_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_id_q <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      busy_q     <= 1'b0;
`ifdef UART_ARB_SRC_TAG_EN
      data_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      busy_q     <= busy_d;
`ifdef UART_ARB_SRC_TAG_EN
      data_q     <= data_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, DBIT=8); inputs change and outputs
// are sampled around the falling clock edge.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_din;
  logic        tx_done_tick;
  logic        busy;
  logic [1:0]  grant_id;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(
    .NREQ(4),
    .DBIT(8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_din      (tx_din),
    .tx_done_tick(tx_done_tick),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered in the SEND cycle; plays the UART: two wait cycles, then a done tick.
  // Returns at the falling edge of the first IDLE cycle.
  task automatic finish_frame();
    @(negedge clk);
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '0; req_data = '0; tx_done_tick = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", tx_start); else n_pass++;
    n_checks++; if (tx_din !== 8'h00) $display("FAIL reset_tx_din: got %h want 00", tx_din); else n_pass++;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    req_data[7:0] = 8'h55; req_valid = 4'b0001; #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (req_ready !== 4'b0000) $display("FAIL single_ready_pulse: got %b want 0000", req_ready); else n_pass++;
    n_checks++; if (tx_start !== 1'b1) $display("FAIL single_start: got %b want 1", tx_start); else n_pass++;
    n_checks++; if (tx_din !== 8'h55) $display("FAIL single_din: got %h want 55", tx_din); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL single_start_once: got %b want 0", tx_start); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_wait: got %b want 1", busy); else n_pass++;
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++; if (tx_din !== 8'h55) $display("FAIL single_din_hold: got %h want 55", tx_din); else n_pass++;
    @(negedge clk);
  endtask

  // ptr is 1 on entry; requester 2 is granted, so ptr becomes 3 before the reset.
  task automatic test_reset_mid_frame();
    req_data[23:16] = 8'hC3; req_valid = 4'b0100; #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL rst_first_ready: got %b want 0100", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (tx_din !== 8'hC3) $display("FAIL rst_first_din: got %h want c3", tx_din); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL rst_wait_busy: got %b want 1", busy); else n_pass++;
    #1 reset_n = 1'b0; #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_async_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (tx_din !== 8'h00) $display("FAIL rst_async_din: got %h want 00", tx_din); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_async_grant: got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL rst_async_start: got %b want 0", tx_start); else n_pass++;
    req_data[15:8] = 8'h5A; req_data[31:24] = 8'hE1; req_valid = 4'b1010;
    @(negedge clk);
    reset_n = 1'b1; #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL rst_ptr_zero: got %b want 0010", req_ready); else n_pass++;
    @(negedge clk); req_valid = 4'b1000; #1;
    n_checks++; if (grant_id !== 2'd1) $display("FAIL rst_grant1: got %0d want 1", grant_id); else n_pass++;
    n_checks++; if (tx_din !== 8'h5A) $display("FAIL rst_din1: got %h want 5a", tx_din); else n_pass++;
    finish_frame(); #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL rst_ready3: got %b want 1000", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (tx_din !== 8'hE1) $display("FAIL rst_din3: got %h want e1", tx_din); else n_pass++;
    finish_frame();
  endtask

  // ptr is 0 on entry: grants must run 0,1,2,3,0 with all four held high.
  task automatic test_round_robin();
    logic [3:0] exp_ready;
    logic [7:0] exp_din;
    req_data = 32'h44332211; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ready = 4'b0001 << (k % 4);
      exp_din = 8'h11 * 8'((k % 4) + 1);
      #1;
      n_checks++; if (req_ready !== exp_ready) $display("FAIL rr_ready_%0d: got %b want %b", k, req_ready, exp_ready); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (tx_start !== 1'b1 || tx_din !== exp_din) $display("FAIL rr_din_%0d: got start=%b din=%h want start=1 din=%h", k, tx_start, tx_din, exp_din); else n_pass++;
      n_checks++; if (grant_id !== 2'(k % 4)) $display("FAIL rr_grant_%0d: got %0d want %0d", k, grant_id, k % 4); else n_pass++;
      finish_frame();
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  // ptr is 1 on entry; grant 3 alone so ptr wraps to 0, then 1001 must go 0 then 3.
  task automatic test_wrap();
    req_data = 32'hD4000000; req_valid = 4'b1000; #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL wrap_pre_ready: got %b want 1000", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0;
    finish_frame();
    req_data = 32'hB70000A9; req_valid = 4'b1001; #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL wrap_ready0: got %b want 0001", req_ready); else n_pass++;
    @(negedge clk); req_valid = 4'b1000; #1;
    n_checks++; if (tx_din !== 8'hA9) $display("FAIL wrap_din0: got %h want a9", tx_din); else n_pass++;
    finish_frame(); #1;
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL wrap_ready3: got %b want 1000", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (grant_id !== 2'd3 || tx_din !== 8'hB7) $display("FAIL wrap_grant3: got id=%0d din=%h want id=3 din=b7", grant_id, tx_din); else n_pass++;
    finish_frame();
  endtask

  task automatic test_spurious_ticks();
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0; #1;
    n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) $display("FAIL spur_idle: got busy=%b start=%b want 0 0", busy, tx_start); else n_pass++;
    req_data = 32'h00009600; req_valid = 4'b0010; #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL spur_ready: got %b want 0010", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0; tx_done_tick = 1'b1; #1;
    n_checks++; if (tx_start !== 1'b1 || tx_din !== 8'h96) $display("FAIL spur_start: got start=%b din=%h want 1 96", tx_start, tx_din); else n_pass++;
    @(negedge clk); tx_done_tick = 1'b0; #1;
    n_checks++; if (busy !== 1'b1 || tx_start !== 1'b0) $display("FAIL spur_send_tick: got busy=%b start=%b want 1 0", busy, tx_start); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL spur_still_wait: got %b want 1", busy); else n_pass++;
    finish_frame(); #1;
    n_checks++; if (busy !== 1'b0 || tx_start !== 1'b0) $display("FAIL spur_end: got busy=%b start=%b want 0 0", busy, tx_start); else n_pass++;
    @(negedge clk);
  endtask

`ifdef UART_ARB_SRC_TAG_EN
  task automatic test_tag();
    req_data = 32'h003C0000; req_valid = 4'b0100; #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL tag_ready: got %b want 0100", req_ready); else n_pass++;
    @(negedge clk); req_valid = '0; #1;
    n_checks++; if (tx_start !== 1'b1 || tx_din !== 8'hA2) $display("FAIL tag_first: got start=%b din=%h want 1 a2", tx_start, tx_din); else n_pass++;
    @(negedge clk); @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0; #1;
    n_checks++; if (tx_start !== 1'b1 || tx_din !== 8'h3C) $display("FAIL tag_second: got start=%b din=%h want 1 3c", tx_start, tx_din); else n_pass++;
    finish_frame(); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL tag_end_busy: got %b want 0", busy); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef UART_ARB_SRC_TAG_EN
    test_tag();
`else
    test_single();
    test_reset_mid_frame();
    test_round_robin();
    test_wrap();
    test_spurious_ticks();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
